operand_pair_sync: RTL and testbench
====================================

Name: operand_pair_sync

Overview:
- Two-lane operand synchronizer that sits directly upstream of the binary comparison/arithmetic dataflow operators.
- Each lane buffers tokens (R_INk/D_INk) from an independent producer in a small FIFO.
- It emits a token on both output lanes in the same cycle only when both lanes hold data. This guarantees the downstream operator sees R_IN1 & R_IN2 together, so no operand is lost to skew.

Parameters:
N, 16, data width of each lane
DEPTH, 4, FIFO entries per lane (power of 2, ≥2)

Ports:
CLK  input  1  rising-edge clock
RST  input  1  asynchronous, active-high reset
EN  input  1  global enable; when 0, no push, no pop, outputs hold
R_IN1  input  1  lane-1 token valid
D_IN1  input  N  lane-1 token data
R_IN2  input  1  lane-2 token valid
D_IN2  input  N  lane-2 token data
FULL1  output  1  lane-1 FIFO holds DEPTH entries
FULL2  output  1  lane-2 FIFO holds DEPTH entries
OVF  output  1  sticky: a valid token was dropped on a full lane
R_OUT1  output  1  paired output valid, lane 1
D_OUT1  output  N  paired output data, lane 1
R_OUT2  output  1  paired output valid, lane 2 (always equal to R_OUT1)
D_OUT2  output  N  paired output data, lane 2

Behaviour:
- Reset (RST=1, asynchronous):
  - All FIFO pointers and counts go to 0.
  - R_OUT1=R_OUT2=0, D_OUT1=D_OUT2=0, OVF=0, FULL1=FULL2=0.
  - Reset asserted mid-stream discards all buffered tokens immediately. No output pulse follows deassertion.
- Per lane k: circular FIFO with write pointer, read pointer (log2(DEPTH) bits, natural wrap) and count (log2(DEPTH)+1 bits, range 0..DEPTH). FULLk = (countk == DEPTH), combinational from the count.
- Pop condition, evaluated each rising edge with EN=1: pop = (count1>0) & (count2>0).
- On pop: both read pointers advance. R_OUT1=R_OUT2 are registered to 1. D_OUT1/D_OUT2 are registered from the heads of FIFO1/FIFO2.
- No pop with EN=1: R_OUT1=R_OUT2 are registered to 0. D_OUT1/D_OUT2 hold their last values.
- Push, per lane, with EN=1: push_k = R_INk & (countk<DEPTH | pop).
  - A full lane accepts a write in the same cycle as a pop.
  - The write goes to the write pointer, which then advances.
- Drop: with EN=1, R_INk=1 and the lane full with no pop, the token is discarded and OVF is set to 1. OVF is cleared only by RST.
- Count update: countk += push_k − pop (push and pop in the same edge leave the count unchanged).
- EN=0:
  - R_INk is ignored (not stored, does not set OVF).
  - Pointers, counts, R_OUT and D_OUT all hold.
  - A pulse already on R_OUT persists while EN=0.
- Latency:
  - A token pair sampled at edge t appears with R_OUT=1 after edge t+1, i.e. two edges.
  - There is no bypass path: an empty FIFO is never read combinationally.
- Throughput: one pair per cycle sustained when both lanes are fed every cycle.
- Ordering: FIFO order within each lane. The i-th lane-1 token is always paired with the i-th lane-2 token.
- Skew: a lane may run up to DEPTH tokens ahead of the other before FULL asserts.

Test Plan:
1. Reset, then EN=1. Drive R_IN1=R_IN2=1 with D_IN1=0x0005, D_IN2=0x0009 for one cycle -> R_OUT1=R_OUT2=1 after the second edge, D_OUT1=0x0005, D_OUT2=0x0009. Next cycle R_OUT=0 and D_OUT holds.
2. Skew: push 0x0001, 0x0002, 0x0003 on lane 1 only -> R_OUT stays 0. Then push 0x00A0 on lane 2 -> a single pair (0x0001, 0x00A0) is output. count1=2 remains.
3. Overflow: push 5 tokens on lane 1 only (DEPTH=4) -> FULL1=1 after the 4th. The 5th is dropped and OVF=1 stays set. Subsequent lane-2 pushes yield pairs with lane-1 data 1,2,3,4 only.
4. Full-with-pop: with lane 1 full and lane 2 holding 1 entry, push on lane 1 in the pop cycle -> token accepted, OVF remains 0, FULL1 stays 1.
5. EN=0 for 3 cycles with R_IN1=R_IN2=1 and a pending pair -> no pop, counts unchanged, R_OUT holds its prior value, OVF unchanged. Resume with EN=1 -> the pending pair emerges.
6. Streaming with mid-stream reset: feed both lanes every cycle with incrementing data 0..7 -> R_OUT=1 continuously from the 2nd edge, with pairs (i,i) in order. Assert RST asynchronously between edges -> outputs go to 0 immediately, FULL=0. After release with no input, no R_OUT pulse occurs.

Source files
------------

// File: rtl/operand_pair_sync.sv
// Two-lane operand synchronizer: each lane buffers tokens in a small FIFO and
// a pair is released on both output lanes only when both FIFOs hold data.
module operand_pair_sync #(
  parameter int N     = 16,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic         R_IN1,
  input  logic [N-1:0] D_IN1,
  input  logic         R_IN2,
  input  logic [N-1:0] D_IN2,
  output logic         FULL1,
  output logic         FULL2,
  output logic         OVF,
  output logic         R_OUT1,
  output logic [N-1:0] D_OUT1,
  output logic         R_OUT2,
  output logic [N-1:0] D_OUT2
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [1:0]        r_in;
  logic [1:0]        ready;
  logic [1:0]        full;
  logic [1:0]        push;
  logic [1:0]        drop;
  logic [1:0][N-1:0] d_in;
  logic [1:0][N-1:0] head;
  logic              pop;
  logic              r_out;
  logic [N-1:0]      d_out1;
  logic [N-1:0]      d_out2;
  logic              ovf;

  assign r_in = {R_IN2, R_IN1};
  assign d_in = {D_IN2, D_IN1};
  assign pop  = &ready;

  for (genvar k = 0; k < 2; k++) begin : g_lane
    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign ready[k] = (count != '0);
    assign full[k]  = (count == CNT_FULL);
    // A full lane can still take a token when the same edge pops its head.
    assign push[k]  = r_in[k] & (~full[k] | pop);
    assign drop[k]  = r_in[k] & full[k] & ~pop;
    assign head[k]  = mem[rd_ptr];

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else if (EN) begin
        if (push[k]) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
        if (push[k] && !pop)      count <= count + CNT_ONE;
        else if (!push[k] && pop) count <= count - CNT_ONE;
      end
    end

    always_ff @(posedge CLK) begin
      if (EN && push[k]) mem[wr_ptr] <= d_in[k];
    end
  end

  // Output stage is registered; with EN low everything, including a pulse, holds.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_out  <= 1'b0;
      d_out1 <= '0;
      d_out2 <= '0;
      ovf    <= 1'b0;
    end else if (EN) begin
      r_out <= pop;
      if (pop) begin
        d_out1 <= head[0];
        d_out2 <= head[1];
      end
      if (|drop) ovf <= 1'b1;
    end
  end

  assign FULL1  = full[0];
  assign FULL2  = full[1];
  assign OVF    = ovf;
  assign R_OUT1 = r_out;
  assign R_OUT2 = r_out;
  assign D_OUT1 = d_out1;
  assign D_OUT2 = d_out2;

endmodule

// File: tb/tb_operand_pair_sync.sv
// Bench for operand_pair_sync: directed vector table, directed streaming/reset
// sequence, and randomized traffic against a queue-based pairing model.
module tb_operand_pair_sync;

  localparam int N     = 16;
  localparam int DEPTH = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         r_in1;
  logic [N-1:0] d_in1;
  logic         r_in2;
  logic [N-1:0] d_in2;
  logic         full1;
  logic         full2;
  logic         ovf;
  logic         r_out1;
  logic [N-1:0] d_out1;
  logic         r_out2;
  logic [N-1:0] d_out2;

  int checks = 0;
  int errors = 0;

  operand_pair_sync #(.N(N), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst), .EN(en),
    .R_IN1(r_in1), .D_IN1(d_in1), .R_IN2(r_in2), .D_IN2(d_in2),
    .FULL1(full1), .FULL2(full2), .OVF(ovf),
    .R_OUT1(r_out1), .D_OUT1(d_out1), .R_OUT2(r_out2), .D_OUT2(d_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           rst;
    bit           en;
    bit           r1;
    logic [N-1:0] d1;
    bit           r2;
    logic [N-1:0] d2;
    bit           e_rout;
    logic [N-1:0] e_d1;
    logic [N-1:0] e_d2;
    bit           e_f1;
    bit           e_f2;
    bit           e_ovf;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: one queue per lane, pairs leave from the fronts together.
  logic [N-1:0] q1[$];
  logic [N-1:0] q2[$];
  bit           m_rout;
  logic [N-1:0] m_d1;
  logic [N-1:0] m_d2;
  bit           m_ovf;

  function automatic void add(bit rs, bit e, bit a1, logic [N-1:0] x1, bit a2, logic [N-1:0] x2,
                              bit ro, logic [N-1:0] o1, logic [N-1:0] o2, bit f1, bit f2, bit ov);
    vec_t v;
    v.rst = rs; v.en = e; v.r1 = a1; v.d1 = x1; v.r2 = a2; v.d2 = x2;
    v.e_rout = ro; v.e_d1 = o1; v.e_d2 = o2; v.e_f1 = f1; v.e_f2 = f2; v.e_ovf = ov;
    tbl.push_back(v);
  endfunction

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input bit e_rout, input logic [N-1:0] e_d1,
                              input logic [N-1:0] e_d2, input bit e_f1, input bit e_f2, input bit e_ovf);
    check_value({tag, " R_OUT1"}, 32'(r_out1), 32'(e_rout));
    check_value({tag, " R_OUT2"}, 32'(r_out2), 32'(e_rout));
    check_value({tag, " D_OUT1"}, 32'(d_out1), 32'(e_d1));
    check_value({tag, " D_OUT2"}, 32'(d_out2), 32'(e_d2));
    check_value({tag, " FULL1"},  32'(full1),  32'(e_f1));
    check_value({tag, " FULL2"},  32'(full2),  32'(e_f2));
    check_value({tag, " OVF"},    32'(ovf),    32'(e_ovf));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    r_in1 = 1'b0; r_in2 = 1'b0;
    q1.delete(); q2.delete();
    m_rout = 1'b0; m_d1 = '0; m_d2 = '0; m_ovf = 1'b0;
    #3;
    rst = 1'b0;
  endtask

  task automatic model_edge();
    if (en) begin
      if (q1.size() > 0 && q2.size() > 0) begin
        m_d1 = q1.pop_front();
        m_d2 = q2.pop_front();
        m_rout = 1'b1;
      end else begin
        m_rout = 1'b0;
      end
      if (r_in1) begin
        if (q1.size() < DEPTH) q1.push_back(d_in1);
        else m_ovf = 1'b1;
      end
      if (r_in2) begin
        if (q2.size() < DEPTH) q2.push_back(d_in2);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic apply_stimulus(input bit e, input bit a1, input logic [N-1:0] x1,
                                input bit a2, input logic [N-1:0] x2);
    en = e; r_in1 = a1; d_in1 = x1; r_in2 = a2; d_in2 = x2;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; r_in1 = 1'b0; d_in1 = '0; r_in2 = 1'b0; d_in2 = '0;
    #1;
    do_reset();
    check_output("reset", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Single pair, then lane skew.
    add(1,1, 1,16'h0005, 1,16'h0009, 0,16'h0000,16'h0000, 0,0,0);
    add(0,1, 0,16'h0000, 0,16'h0000, 1,16'h0005,16'h0009, 0,0,0);
    add(0,1, 0,16'h0000, 0,16'h0000, 0,16'h0005,16'h0009, 0,0,0);
    add(0,1, 1,16'h0001, 0,16'h0000, 0,16'h0005,16'h0009, 0,0,0);
    add(0,1, 1,16'h0002, 0,16'h0000, 0,16'h0005,16'h0009, 0,0,0);
    add(0,1, 1,16'h0003, 0,16'h0000, 0,16'h0005,16'h0009, 0,0,0);
    add(0,1, 0,16'h0000, 1,16'h00A0, 0,16'h0005,16'h0009, 0,0,0);
    add(0,1, 0,16'h0000, 0,16'h0000, 1,16'h0001,16'h00A0, 0,0,0);
    add(0,1, 0,16'h0000, 0,16'h0000, 0,16'h0001,16'h00A0, 0,0,0);
    // Overflow on lane 1; the dropped fifth token never pairs.
    add(1,1, 1,16'h0001, 0,16'h0000, 0,16'h0000,16'h0000, 0,0,0);
    add(0,1, 1,16'h0002, 0,16'h0000, 0,16'h0000,16'h0000, 0,0,0);
    add(0,1, 1,16'h0003, 0,16'h0000, 0,16'h0000,16'h0000, 0,0,0);
    add(0,1, 1,16'h0004, 0,16'h0000, 0,16'h0000,16'h0000, 1,0,0);
    add(0,1, 1,16'h0005, 0,16'h0000, 0,16'h0000,16'h0000, 1,0,1);
    add(0,1, 0,16'h0000, 1,16'h00B1, 0,16'h0000,16'h0000, 1,0,1);
    add(0,1, 0,16'h0000, 1,16'h00B2, 1,16'h0001,16'h00B1, 0,0,1);
    add(0,1, 0,16'h0000, 1,16'h00B3, 1,16'h0002,16'h00B2, 0,0,1);
    add(0,1, 0,16'h0000, 1,16'h00B4, 1,16'h0003,16'h00B3, 0,0,1);
    add(0,1, 0,16'h0000, 1,16'h00B5, 1,16'h0004,16'h00B4, 0,0,1);
    add(0,1, 0,16'h0000, 0,16'h0000, 0,16'h0004,16'h00B4, 0,0,1);
    // Full lane accepts a write in the pop cycle.
    add(1,1, 1,16'h0001, 0,16'h0000, 0,16'h0000,16'h0000, 0,0,0);
    add(0,1, 1,16'h0002, 0,16'h0000, 0,16'h0000,16'h0000, 0,0,0);
    add(0,1, 1,16'h0003, 0,16'h0000, 0,16'h0000,16'h0000, 0,0,0);
    add(0,1, 1,16'h0004, 1,16'h00C1, 0,16'h0000,16'h0000, 1,0,0);
    add(0,1, 1,16'h0005, 0,16'h0000, 1,16'h0001,16'h00C1, 1,0,0);
    add(0,1, 0,16'h0000, 0,16'h0000, 0,16'h0001,16'h00C1, 1,0,0);
    add(0,1, 0,16'h0000, 1,16'h00C2, 0,16'h0001,16'h00C1, 1,0,0);
    add(0,1, 0,16'h0000, 1,16'h00C3, 1,16'h0002,16'h00C2, 0,0,0);
    add(0,1, 0,16'h0000, 1,16'h00C4, 1,16'h0003,16'h00C3, 0,0,0);
    add(0,1, 0,16'h0000, 1,16'h00C5, 1,16'h0004,16'h00C4, 0,0,0);
    add(0,1, 0,16'h0000, 0,16'h0000, 1,16'h0005,16'h00C5, 0,0,0);
    // Enable low freezes a live pulse and ignores inputs.
    add(0,1, 1,16'h0021, 1,16'h0022, 0,16'h0005,16'h00C5, 0,0,0);
    add(0,1, 1,16'h0031, 1,16'h0032, 1,16'h0021,16'h0022, 0,0,0);
    add(0,0, 1,16'h0099, 1,16'h0099, 1,16'h0021,16'h0022, 0,0,0);
    add(0,0, 1,16'h0099, 1,16'h0099, 1,16'h0021,16'h0022, 0,0,0);
    add(0,0, 1,16'h0099, 1,16'h0099, 1,16'h0021,16'h0022, 0,0,0);
    add(0,1, 0,16'h0000, 0,16'h0000, 1,16'h0031,16'h0032, 0,0,0);
    add(0,1, 0,16'h0000, 0,16'h0000, 0,16'h0031,16'h0032, 0,0,0);
    add(0,1, 0,16'h0000, 0,16'h0000, 0,16'h0031,16'h0032, 0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      apply_stimulus(tbl[i].en, tbl[i].r1, tbl[i].d1, tbl[i].r2, tbl[i].d2);
      check_output($sformatf("vec%0d", i), tbl[i].e_rout, tbl[i].e_d1, tbl[i].e_d2,
                   tbl[i].e_f1, tbl[i].e_f2, tbl[i].e_ovf);
    end

    // Streaming at full rate, then an asynchronous reset between edges.
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      apply_stimulus(1'b1, 1'b1, N'(i), 1'b1, N'(i));
      check_output($sformatf("stream%0d", i), i > 0, (i > 0) ? N'(i - 1) : '0,
                   (i > 0) ? N'(i - 1) : '0, 1'b0, 1'b0, 1'b0);
    end
    #2;
    rst = 1'b1;
    #1;
    check_output("async_rst", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    r_in1 = 1'b0; r_in2 = 1'b0;
    #1;
    rst = 1'b0;
    q1.delete(); q2.delete();
    m_rout = 1'b0; m_d1 = '0; m_d2 = '0; m_ovf = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b0, '0, 1'b0, '0);
      check_output($sformatf("post_rst%0d", i), 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    end

    // Randomized traffic with per-block lane bias to create skew and overflow.
    do_reset();
    for (int blk = 0; blk < 8; blk++) begin
      int p1 = $urandom_range(1, 9);
      int p2 = $urandom_range(1, 9);
      for (int c = 0; c < 50; c++) begin
        apply_stimulus($urandom_range(0, 9) != 0,
                       $urandom_range(0, 9) < p1, N'($urandom),
                       $urandom_range(0, 9) < p2, N'($urandom));
        check_output($sformatf("rand%0d_%0d", blk, c), m_rout, m_d1, m_d2,
                     q1.size() == DEPTH, q2.size() == DEPTH, m_ovf);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
